// File: rtl/neuron_array_if.sv
// rtl/neuron_array_if.sv - configuration, spike and output handshake bundle for neuron_array

interface neuron_array_if #(
    parameter int NUM_LANES       = 4,
    parameter int NEURON_ID_WIDTH = 7,
    parameter int VMEM_WIDTH      = 16,
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int LANE_WIDTH      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
    logic                                      en_neuron;
    logic                                      cfg_valid;
    logic                                      cfg_ready;
    logic [1:0]                                cfg_sel;
    logic [LANE_WIDTH-1:0]                     cfg_lane;
    logic [VMEM_WIDTH-1:0]                     cfg_data;
    logic [NEURON_ID_WIDTH:0]                  active_neuron;
    logic                                      run;
    logic                                      stop;
    logic                                      spike_valid;
    logic                                      spike_ready;
    logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [2*NUM_LANES-1:0]                    spike_out;
    logic [4*NUM_LANES-1:0]                    cfg_done;
    logic                                      all_done;
    logic                                      busy;

    modport master (
        output en_neuron, cfg_valid, cfg_sel, cfg_lane, cfg_data, active_neuron,
               run, stop, spike_valid, spike_in, out_ready,
        input  cfg_ready, spike_ready, out_valid, spike_out, cfg_done, all_done, busy
    );

    modport slave (
        input  en_neuron, cfg_valid, cfg_sel, cfg_lane, cfg_data, active_neuron,
               run, stop, spike_valid, spike_in, out_ready,
        output cfg_ready, spike_ready, out_valid, spike_out, cfg_done, all_done, busy
    );
endinterface

// File: rtl/neuron_array.sv
// rtl/neuron_array.sv - multi-lane Ising-style neuron array with coupling memory and spike handshakes

module neuron_array #(
    parameter int NUM_LANES       = 4,
    parameter int NUM_NEURON      = 128,
    parameter int NEURON_ID_WIDTH = 7,
    parameter int VMEM_WIDTH      = 16,
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int STEP            = 2,
    parameter int LANE_WIDTH      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input logic           clk,
    input logic           reset,
    neuron_array_if.slave bus
);
    localparam int SPIKE_W = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
    localparam int QPTR_W  = NEURON_ID_WIDTH + 1;

    localparam logic signed [VMEM_WIDTH-1:0] VMAX     = {1'b0, {(VMEM_WIDTH-1){1'b1}}};
    localparam logic signed [VMEM_WIDTH-1:0] VMIN     = {1'b1, {(VMEM_WIDTH-1){1'b0}}};
    localparam logic signed [VMEM_WIDTH-1:0] STEP_POS = VMEM_WIDTH'(STEP);
    localparam logic signed [VMEM_WIDTH-1:0] STEP_NEG = -STEP_POS;

    localparam logic [TEN_DATA_WIDTH-1:0] CODE_NEG = TEN_DATA_WIDTH'(1);
    localparam logic [TEN_DATA_WIDTH-1:0] CODE_POS = TEN_DATA_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_OUT,
        S_RECV,
        S_UPDATE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Per-lane neuron state
    logic signed [VMEM_WIDTH-1:0]      r_vmem     [NUM_LANES];
    logic signed [VMEM_WIDTH-1:0]      r_mu       [NUM_LANES];
    logic        [NEURON_ID_WIDTH-1:0] r_neuron_i [NUM_LANES];
    logic        [QPTR_W-1:0]          r_qptr     [NUM_LANES];
    logic        [NUM_LANES-1:0]       r_spin;
    logic        [4*NUM_LANES-1:0]     r_done;

    // Coupling memory (not reset) and its registered read port
    logic [1:0] r_q_mem [NUM_LANES][NUM_NEURON];
    logic [1:0] r_q_rd  [NUM_LANES];

    // Latched incoming spike and registered outgoing spike codes
    logic [TEN_DATA_WIDTH-1:0]  r_code;
    logic [NEURON_ID_WIDTH-1:0] r_id;
    logic [2*NUM_LANES-1:0]     r_spike_out;

    logic                          w_cfg_ready;
    logic                          w_spike_ready;
    logic                          w_out_valid;
    logic                          w_busy;
    logic                          w_all_done;
    logic                          w_cfg_fire;
    logic                          w_spike_fire;
    logic [TEN_DATA_WIDTH-1:0]     w_spike_code;
    logic [NEURON_ID_WIDTH-1:0]    w_spike_id;
    logic [2*NUM_LANES-1:0]        w_emit_code;
    logic signed [VMEM_WIDTH-1:0]  w_vmem_upd [NUM_LANES];
    logic [NUM_LANES-1:0]          w_spin_tgl;
    logic [NUM_LANES-1:0]          w_q_last;

    // Saturating signed add so membrane potentials pin at the rails instead of wrapping
    function automatic logic signed [VMEM_WIDTH-1:0] f_sat_add(
        input logic signed [VMEM_WIDTH-1:0] i_a,
        input logic signed [VMEM_WIDTH-1:0] i_b
    );
        logic [VMEM_WIDTH:0] w_sum;
        w_sum = {i_a[VMEM_WIDTH-1], i_a} + {i_b[VMEM_WIDTH-1], i_b};
        if (w_sum[VMEM_WIDTH] != w_sum[VMEM_WIDTH-1]) begin
            return w_sum[VMEM_WIDTH] ? VMIN : VMAX;
        end
        return w_sum[VMEM_WIDTH-1:0];
    endfunction

    assign w_all_done   = &r_done;
    assign w_cfg_fire   = bus.cfg_valid && w_cfg_ready && bus.en_neuron;
    assign w_spike_fire = bus.spike_valid && w_spike_ready && bus.en_neuron;
    assign w_spike_code = bus.spike_in[SPIKE_W-1 -: TEN_DATA_WIDTH];
    assign w_spike_id   = bus.spike_in[NEURON_ID_WIDTH-1:0];

    // Per-lane combinational spike decision, coupling update and load-pointer wrap
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic signed [VMEM_WIDTH-1:0] w_mag;
        logic                         w_inc;
        logic                         w_dec;
        logic                         w_fire;

        // Spin-down lanes look at the negated potential; negating the most negative value saturates
        assign w_mag  = r_spin[l] ? r_vmem[l]
                                  : ((r_vmem[l] == VMIN) ? VMAX : -r_vmem[l]);
        assign w_fire = (w_mag > r_mu[l]);
        assign w_emit_code[2*l +: 2] = w_fire ? (r_spin[l] ? 2'd2 : 2'd1) : 2'd0;

        // Matching code/coupling pulls the potential up, opposite pairing pulls it down
        assign w_inc = ((r_code == CODE_NEG) && (r_q_rd[l] == 2'd1)) ||
                       ((r_code == CODE_POS) && (r_q_rd[l] == 2'd2));
        assign w_dec = ((r_code == CODE_NEG) && (r_q_rd[l] == 2'd2)) ||
                       ((r_code == CODE_POS) && (r_q_rd[l] == 2'd1));
        assign w_vmem_upd[l] = w_inc ? f_sat_add(r_vmem[l], STEP_POS) :
                               w_dec ? f_sat_add(r_vmem[l], STEP_NEG) : r_vmem[l];

        assign w_spin_tgl[l] = (r_id == r_neuron_i[l]) &&
                               ((r_code == CODE_NEG) || (r_code == CODE_POS));

        // The final beat also wraps if the pointer would run off the end of the memory
        assign w_q_last[l] = (r_qptr[l] == bus.active_neuron - QPTR_W'(1)) ||
                             (r_qptr[l] == QPTR_W'(NUM_NEURON - 1));
    end

    // State register; every transition is gated by the clock enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (bus.en_neuron) begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state handshake outputs
    always_comb begin
        w_next        = r_state;
        w_cfg_ready   = 1'b0;
        w_spike_ready = 1'b0;
        w_out_valid   = 1'b0;
        w_busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cfg_ready = 1'b1;
                w_busy      = 1'b0;
                if (bus.run && w_all_done) begin
                    w_next = S_EMIT;
                end
            end
            S_EMIT: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_RECV;
                end
            end
            S_RECV: begin
                w_spike_ready = 1'b1;
                if (bus.spike_valid) begin
                    w_next = S_UPDATE;
                end else if (bus.stop) begin
                    w_next = S_IDLE;
                end
            end
            S_UPDATE: begin
                w_next = S_EMIT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Lane registers: configuration beats in IDLE, potential/spin update in UPDATE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_vmem[l]     <= '0;
                r_mu[l]       <= '0;
                r_neuron_i[l] <= '0;
                r_qptr[l]     <= '0;
            end
            r_spin <= '1;
            r_done <= '0;
        end else if (bus.en_neuron) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (w_cfg_fire && (bus.cfg_lane == LANE_WIDTH'(l))) begin
                    case (bus.cfg_sel)
                        2'd0: begin
                            if (w_q_last[l]) begin
                                r_qptr[l]   <= '0;
                                r_done[4*l] <= 1'b1;
                            end else begin
                                r_qptr[l] <= r_qptr[l] + QPTR_W'(1);
                                if (r_qptr[l] == '0) begin
                                    r_done[4*l] <= 1'b0;
                                end
                            end
                        end
                        2'd1: begin
                            r_vmem[l]     <= $signed(bus.cfg_data);
                            r_spin[l]     <= 1'b1;
                            r_done[4*l+1] <= 1'b1;
                        end
                        2'd2: begin
                            r_neuron_i[l] <= bus.cfg_data[NEURON_ID_WIDTH-1:0];
                            r_done[4*l+2] <= 1'b1;
                        end
                        default: begin
                            r_mu[l]       <= $signed(bus.cfg_data);
                            r_done[4*l+3] <= 1'b1;
                        end
                    endcase
                end else if (r_state == S_UPDATE) begin
                    r_vmem[l] <= w_vmem_upd[l];
                    if (w_spin_tgl[l]) begin
                        r_spin[l] <= ~r_spin[l];
                    end
                end
            end
        end
    end

    // Spike latch on accept and spike-code register loaded in EMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code      <= '0;
            r_id        <= '0;
            r_spike_out <= '0;
        end else if (bus.en_neuron) begin
            if (w_spike_fire) begin
                r_code <= w_spike_code;
                r_id   <= w_spike_id;
            end
            if (r_state == S_EMIT) begin
                r_spike_out <= w_emit_code;
            end
        end
    end

    // Coupling memory write on Q beats and read with the address taken at spike accept
    always_ff @(posedge clk) begin
        if (bus.en_neuron && !reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (w_cfg_fire && (bus.cfg_sel == 2'd0) && (bus.cfg_lane == LANE_WIDTH'(l))) begin
                    r_q_mem[l][r_qptr[l][NEURON_ID_WIDTH-1:0]] <= bus.cfg_data[1:0];
                end
                if (w_spike_fire) begin
                    r_q_rd[l] <= r_q_mem[l][w_spike_id];
                end
            end
        end
    end

    assign bus.cfg_ready   = w_cfg_ready;
    assign bus.spike_ready = w_spike_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.spike_out   = r_spike_out;
    assign bus.cfg_done    = r_done;
    assign bus.all_done    = w_all_done;
    assign bus.busy        = w_busy;

endmodule

// File: tb/tb_neuron_array.sv
// tb/tb_neuron_array.sv - randomized self-checking bench for neuron_array against a lane-level model

module tb_neuron_array;
    localparam int NL = 4;

    logic clk = 1'b0;
    logic reset;

    neuron_array_if bus ();

    neuron_array dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_vmem [NL];
    int m_mu   [NL];
    int m_ni   [NL];
    int m_spin [NL];
    int m_qptr [NL];
    int m_q    [NL][128];
    logic [4*NL-1:0] m_done;
    int m_active;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [2*NL-1:0] exp_spikes();
        logic [2*NL-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++) begin
            int s;
            s = (m_spin[l] != 0) ? m_vmem[l] : clamp(-m_vmem[l]);
            if (s > m_mu[l]) r[2*l +: 2] = (m_spin[l] != 0) ? 2'd2 : 2'd1;
        end
        return r;
    endfunction

    task automatic model_cfg(input int sel, input int lane, input int data);
        case (sel)
            0: begin
                m_q[lane][m_qptr[lane]] = data & 3;
                if (m_qptr[lane] == m_active - 1) begin
                    m_qptr[lane] = 0;
                    m_done[4*lane] = 1'b1;
                end else begin
                    if (m_qptr[lane] == 0) m_done[4*lane] = 1'b0;
                    m_qptr[lane]++;
                end
            end
            1: begin m_vmem[lane] = data; m_spin[lane] = 1; m_done[4*lane+1] = 1'b1; end
            2: begin m_ni[lane] = data & 127; m_done[4*lane+2] = 1'b1; end
            default: begin m_mu[lane] = data; m_done[4*lane+3] = 1'b1; end
        endcase
    endtask

    task automatic model_spike(input int code, input int id);
        for (int l = 0; l < NL; l++) begin
            int q;
            q = m_q[l][id];
            if ((code == 1 && q == 1) || (code == 2 && q == 2)) m_vmem[l] = clamp(m_vmem[l] + 2);
            else if ((code == 1 && q == 2) || (code == 2 && q == 1)) m_vmem[l] = clamp(m_vmem[l] - 2);
            if (id == m_ni[l] && (code == 1 || code == 2)) m_spin[l] = 1 - m_spin[l];
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            m_vmem[l] = 0; m_mu[l] = 0; m_ni[l] = 0; m_spin[l] = 1; m_qptr[l] = 0;
        end
        m_done = '0;
    endtask

    task automatic cfg_beat(input int sel, input int lane, input int data, input bit apply);
        bus.cfg_valid = 1'b1;
        bus.cfg_sel   = 2'(sel);
        bus.cfg_lane  = 2'(lane);
        bus.cfg_data  = 16'(data);
        tick();
        bus.cfg_valid = 1'b0;
        if (apply) model_cfg(sel, lane, data);
    endtask

    task automatic load_lane(input int lane, input int vmem, input int mu, input int ni);
        for (int i = 0; i < m_active; i++) cfg_beat(0, lane, int'($urandom_range(3)), 1'b1);
        cfg_beat(1, lane, vmem, 1'b1);
        cfg_beat(2, lane, ni, 1'b1);
        cfg_beat(3, lane, mu, 1'b1);
    endtask

    task automatic do_run();
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL run_lat1: busy=%0b out_valid=%0b want busy=1 out_valid=0", bus.busy, bus.out_valid);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL run_lat2: out_valid=%0b want 1", bus.out_valid);
        end
        n_cmp++;
        if (bus.spike_out !== exp_spikes()) begin
            n_bad++;
            $display("FAIL run_emit: spike_out=%h want %h", bus.spike_out, exp_spikes());
        end
    endtask

    task automatic do_out(input int delay);
        for (int i = 0; i < delay; i++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.spike_out !== exp_spikes()) begin
                n_bad++;
                $display("FAIL out_hold: out_valid=%0b spike_out=%h want 1 %h", bus.out_valid, bus.spike_out, exp_spikes());
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.spike_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL recv_enter: spike_ready=%0b out_valid=%0b want 1 0", bus.spike_ready, bus.out_valid);
        end
    endtask

    task automatic do_spike(input int code, input int id);
        bus.spike_valid = 1'b1;
        bus.spike_in    = {2'(code), 7'(id)};
        tick();
        bus.spike_valid = 1'b0;
        model_spike(code, id);
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL spk_lat2: out_valid=%0b busy=%0b want 0 1", bus.out_valid, bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL spk_lat3: out_valid=%0b want 1", bus.out_valid);
        end
        n_cmp++;
        if (bus.spike_out !== exp_spikes()) begin
            n_bad++;
            $display("FAIL spk_out: spike_out=%h want %h (code %0d id %0d)", bus.spike_out, exp_spikes(), code, id);
        end
        for (int l = 0; l < NL; l++) begin
            n_cmp++;
            if (dut.r_vmem[l] !== 16'(m_vmem[l])) begin
                n_bad++;
                $display("FAIL vmem_lane%0d: got %0d want %0d", l, dut.r_vmem[l], m_vmem[l]);
            end
        end
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_idle: busy=%0b cfg_ready=%0b want 0 1", bus.busy, bus.cfg_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.spike_ready !== 1'b0 ||
            bus.spike_out !== '0 || bus.cfg_done !== '0 || bus.all_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%0b ov=%0b sr=%0b so=%h done=%h all=%0b want all 0",
                     bus.busy, bus.out_valid, bus.spike_ready, bus.spike_out, bus.cfg_done, bus.all_done);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (bus.cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_cfg_ready: got %0b want 1", bus.cfg_ready);
        end
        model_reset();
    endtask

    task automatic test_config();
        int qv [4];
        qv = '{1, 2, 0, 1};
        m_active = 4;
        bus.active_neuron = 8'd4;
        for (int i = 0; i < 4; i++) begin
            cfg_beat(0, 0, qv[i], 1'b1);
            n_cmp++;
            if (bus.cfg_done[0] !== m_done[0] || bus.all_done !== 1'b0) begin
                n_bad++;
                $display("FAIL q_done_beat%0d: done=%0b all=%0b want %0b 0", i, bus.cfg_done[0], bus.all_done, m_done[0]);
            end
        end
        n_cmp++;
        if (dut.r_qptr[0] !== 8'd0 || bus.cfg_done[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL q_wrap: qptr=%0d done=%0b want 0 1", dut.r_qptr[0], bus.cfg_done[0]);
        end
        cfg_beat(1, 0, 10, 1'b1);
        cfg_beat(2, 0, 3, 1'b1);
        cfg_beat(3, 0, 5, 1'b1);
        for (int l = 1; l < NL; l++) begin
            n_cmp++;
            if (bus.all_done !== 1'b0) begin
                n_bad++;
                $display("FAIL all_done_early: lane %0d got %0b want 0", l, bus.all_done);
            end
            load_lane(l, int'($urandom_range(60)) - 30, int'($urandom_range(20)) - 10, int'($urandom_range(3)));
        end
        n_cmp++;
        if (bus.cfg_done !== m_done || bus.all_done !== 1'b1) begin
            n_bad++;
            $display("FAIL all_done: done=%h all=%0b want %h 1", bus.cfg_done, bus.all_done, m_done);
        end
    endtask

    task automatic test_emit_hold();
        do_run();
        n_cmp++;
        if (bus.spike_out[1:0] !== 2'd2) begin
            n_bad++;
            $display("FAIL emit_lane0: got %0d want 2", bus.spike_out[1:0]);
        end
        do_out(5);
    endtask

    task automatic test_update();
        do_spike(1, 1);
        n_cmp++;
        if (dut.r_vmem[0] !== 16'sd8) begin
            n_bad++;
            $display("FAIL update_dec: got %0d want 8", dut.r_vmem[0]);
        end
        do_out(0);
        do_spike(1, 0);
        n_cmp++;
        if (dut.r_vmem[0] !== 16'sd10) begin
            n_bad++;
            $display("FAIL update_inc: got %0d want 10", dut.r_vmem[0]);
        end
        do_out(0);
        do_stop();
    endtask

    task automatic test_spin();
        cfg_beat(1, 0, -8, 1'b1);
        do_run();
        do_out(1);
        do_spike(2, 3);
        n_cmp++;
        if (bus.spike_out[1:0] !== 2'd1 || dut.r_spin[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL spin_flip: code=%0d spin=%0b want 1 0", bus.spike_out[1:0], dut.r_spin[0]);
        end
        do_out(0);
        do_stop();
    endtask

    task automatic test_saturation();
        cfg_beat(1, 0, 32767, 1'b1);
        do_run();
        do_out(0);
        do_spike(1, 0);
        n_cmp++;
        if (dut.r_vmem[0] !== 16'sd32767) begin
            n_bad++;
            $display("FAIL sat_max: got %0d want 32767", dut.r_vmem[0]);
        end
        do_out(0);
        do_stop();
        cfg_beat(1, 0, -32768, 1'b1);
        do_run();
        do_out(0);
        do_spike(1, 1);
        n_cmp++;
        if (dut.r_vmem[0] !== -16'sd32768) begin
            n_bad++;
            $display("FAIL sat_min: got %0d want -32768", dut.r_vmem[0]);
        end
        do_out(0);
        do_spike(2, 3);
        do_out(0);
        do_stop();
    endtask

    task automatic test_guards();
        do_run();
        bus.stop      = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_sel   = 2'd1;
        bus.cfg_lane  = 2'd0;
        bus.cfg_data  = 16'd99;
        tick();
        bus.stop      = 1'b0;
        bus.cfg_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || dut.r_vmem[0] !== 16'(m_vmem[0])) begin
            n_bad++;
            $display("FAIL guard_out: out_valid=%0b vmem=%0d want 1 %0d", bus.out_valid, dut.r_vmem[0], m_vmem[0]);
        end
        bus.en_neuron = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        bus.en_neuron = 1'b1;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL en_hold_out: out_valid=%0b want 1", bus.out_valid);
        end
        do_out(0);
        do_stop();
        bus.en_neuron = 1'b0;
        cfg_beat(1, 1, 1234, 1'b0);
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        bus.en_neuron = 1'b1;
        n_cmp++;
        if (dut.r_vmem[1] !== 16'(m_vmem[1]) || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL en_hold_idle: vmem=%0d busy=%0b want %0d 0", dut.r_vmem[1], bus.busy, m_vmem[1]);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            for (int l = 0; l < NL; l++) begin
                load_lane(l, int'($urandom_range(80)) - 40, int'($urandom_range(20)) - 10, int'($urandom_range(3)));
            end
            do_run();
            for (int k = 0; k < 20; k++) begin
                do_out(int'($urandom_range(3)));
                do_spike(int'($urandom_range(3)), int'($urandom_range(3)));
            end
            do_out(0);
            do_stop();
        end
    endtask

    task automatic test_reset_mid();
        do_run();
        do_out(0);
        bus.spike_valid = 1'b1;
        bus.spike_in    = {2'd2, 7'd0};
        tick();
        bus.spike_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.spike_ready !== 1'b0 ||
            bus.spike_out !== '0 || bus.cfg_done !== '0 || bus.all_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: busy=%0b ov=%0b sr=%0b so=%h done=%h want all 0",
                     bus.busy, bus.out_valid, bus.spike_ready, bus.spike_out, bus.cfg_done);
        end
        model_reset();
        #3;
        reset = 1'b0;
        tick();
        n_cmp++;
        if (bus.cfg_ready !== 1'b1 || dut.r_vmem[0] !== 16'sd0) begin
            n_bad++;
            $display("FAIL reset_release: cfg_ready=%0b vmem=%0d want 1 0", bus.cfg_ready, dut.r_vmem[0]);
        end
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL run_needs_done: busy=%0b want 0", bus.busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.en_neuron     = 1'b1;
        bus.cfg_valid     = 1'b0;
        bus.cfg_sel       = 2'd0;
        bus.cfg_lane      = 2'd0;
        bus.cfg_data      = 16'd0;
        bus.active_neuron = 8'd4;
        bus.run           = 1'b0;
        bus.stop          = 1'b0;
        bus.spike_valid   = 1'b0;
        bus.spike_in      = '0;
        bus.out_ready     = 1'b0;
        m_active          = 4;
        for (int l = 0; l < NL; l++) for (int i = 0; i < 128; i++) m_q[l][i] = 0;
        model_reset();

        test_reset();
        test_config();
        test_emit_hold();
        test_update();
        test_spin();
        test_saturation();
        test_guards();
        test_random();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
